// File: rtl/sl_pkg.sv
// Shared definitions for the SL transmitter: config/status field positions,
// FSM state and line symbol encodings, data-width limits and a mask helper.
package sl_pkg;

  // Config register fields
  localparam int unsigned CfgPinv = 0;
  localparam int unsigned CfgBql  = 1;
  localparam int unsigned CfgBqh  = 6;
  localparam int unsigned CfgMode = 7;
  localparam int unsigned CfgIrqm = 8;

  // Status register bits
  localparam int unsigned StatBsy = 0;
  localparam int unsigned StatTxd = 1;
  localparam int unsigned StatCrj = 2;

  // Legal data bit quantity range
  localparam int unsigned BqMin = 8;
  localparam int unsigned BqMax = 32;

  typedef enum logic [1:0] {StIdle, StLow, StGap, StDone} sl_state_e;

  typedef enum logic [1:0] {SymOne, SymZero, SymStop} sl_sym_e;

  // Mask with the low bq bits set; bq = 32 gives all ones.
  function automatic logic [31:0] bq_mask(input logic [5:0] bq);
    logic [63:0] m;
    m = (64'd1 << bq) - 64'd1;
    return m[31:0];
  endfunction

endpackage

// File: rtl/sl_symbol_driver.sv
// Drives one SL symbol onto the line pair: lines low for BitLowCycles
// according to the symbol, then both high for GapCycles.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   start_i, sym_i     start a symbol (sym_i uses sl_sym_e encoding)
//   zeroes_o, ones_o   registered line outputs, idle high
//   low_last_o         last cycle of the low phase
//   sym_done_o         last cycle of the gap; a start here gives back-to-back symbols
module sl_symbol_driver
  import sl_pkg::*;
#(
  parameter int unsigned BitLowCycles = 16,
  parameter int unsigned GapCycles    = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [1:0] sym_i,
  output logic       zeroes_o,
  output logic       ones_o,
  output logic       low_last_o,
  output logic       sym_done_o
);

  localparam int unsigned CntMax = (BitLowCycles > GapCycles) ? BitLowCycles : GapCycles;
  localparam int unsigned CntW   = $clog2(CntMax);

  typedef enum logic [1:0] {PhIdle, PhLow, PhGap} phase_e;

  phase_e          phase_q, phase_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            zeroes_q, zeroes_d;
  logic            ones_q, ones_d;

  assign low_last_o = (phase_q == PhLow) && (cnt_q == CntW'(BitLowCycles - 1));
  assign sym_done_o = (phase_q == PhGap) && (cnt_q == CntW'(GapCycles - 1));
  assign zeroes_o   = zeroes_q;
  assign ones_o     = ones_q;

  always_comb begin
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    zeroes_d = zeroes_q;
    ones_d   = ones_q;
    if (start_i) begin
      // A '1' pulls the ones line, a '0' the zeroes line, stop pulls both.
      phase_d  = PhLow;
      cnt_d    = '0;
      zeroes_d = (sym_i == SymOne);
      ones_d   = (sym_i == SymZero);
    end else begin
      unique case (phase_q)
        PhLow: begin
          if (low_last_o) begin
            phase_d  = PhGap;
            cnt_d    = '0;
            zeroes_d = 1'b1;
            ones_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PhGap: begin
          if (sym_done_o) begin
            phase_d = PhIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q  <= PhIdle;
      cnt_q    <= '0;
      zeroes_q <= 1'b1;
      ones_q   <= 1'b1;
    end else begin
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      zeroes_q <= zeroes_d;
      ones_q   <= ones_d;
    end
  end

endmodule

// File: rtl/sl_transmitter.sv
// SL word transmitter: accepts a word via valid/ready, sends BQ data bits
// LSB first, then an odd-parity bit (optionally inverted), then a stop symbol.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   wr_config_w, wr_enable          config write
//   tx_data_w, tx_valid, tx_ready   word handshake
//   serial_line_zeroes/_ones        SL line pair, idle high
//   status_w                        [0] BSY, [1] TXD, [2] CRJ
//   r_config_w                      current config ([0] PINV, [6:1] BQ)
module sl_transmitter
  import sl_pkg::*;
#(
  parameter int unsigned BIT_LOW_CYCLES = 16,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter logic [15:0] CFG_RESET      = 16'h0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] wr_config_w,
  input  logic        wr_enable,
  input  logic [31:0] tx_data_w,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        serial_line_zeroes,
  output logic        serial_line_ones,
  output logic [15:0] status_w,
  output logic [15:0] r_config_w
);

  sl_state_e   state_q, state_d;
  logic [15:0] cfg_q, cfg_d;
  logic [31:0] data_q, data_d;
  logic [5:0]  bq_q, bq_d;
  logic [5:0]  sym_cnt_q, sym_cnt_d;
  logic        par_q, par_d;
  logic        bsy_q, bsy_d;
  logic        txd_q, txd_d;
  logic        crj_q, crj_d;

  logic        accept;
  logic [5:0]  cur_bq;
  logic [5:0]  new_bq;
  logic [31:0] masked;
  logic        new_par;
  logic        cfg_ok;
  logic        start;
  sl_sym_e     sym;
  logic        low_last;
  logic        sym_done;

  // Symbol index: 0..bq-1 data, bq parity, bq+1 stop.
  function automatic sl_sym_e sym_for(input logic [5:0] idx, input logic [31:0] d,
                                      input logic p, input logic [5:0] bq);
    if (idx < bq) return d[idx[4:0]] ? SymOne : SymZero;
    else if (idx == bq) return p ? SymOne : SymZero;
    else return SymStop;
  endfunction

  assign tx_ready   = (state_q == StIdle);
  assign accept     = tx_ready && tx_valid;
  assign cur_bq     = cfg_q[CfgBqh:CfgBql];
  assign new_bq     = wr_config_w[CfgBqh:CfgBql];
  assign masked     = tx_data_w & bq_mask(cur_bq);
  assign new_par    = (~^masked) ^ cfg_q[CfgPinv];
  assign cfg_ok     = wr_enable && (state_q == StIdle) && !accept &&
                      (new_bq >= 6'(BqMin)) && (new_bq <= 6'(BqMax));
  assign status_w   = {13'd0, crj_q, txd_q, bsy_q};
  assign r_config_w = cfg_q;

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    data_d    = data_q;
    bq_d      = bq_q;
    sym_cnt_d = sym_cnt_q;
    par_d     = par_q;
    bsy_d     = bsy_q;
    txd_d     = txd_q;
    crj_d     = crj_q;
    start     = 1'b0;
    sym       = SymStop;

    if (wr_enable) begin
      if (cfg_ok) begin
        cfg_d = wr_config_w;
        crj_d = 1'b0;
      end else begin
        crj_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          data_d    = masked;
          bq_d      = cur_bq;
          par_d     = new_par;
          sym_cnt_d = 6'd0;
          start     = 1'b1;
          sym       = sym_for(6'd0, masked, new_par, cur_bq);
          bsy_d     = 1'b1;
          txd_d     = 1'b0;
          state_d   = StLow;
        end
      end
      StLow: begin
        if (low_last) state_d = StGap;
      end
      StGap: begin
        if (sym_done) begin
          if (sym_cnt_q == bq_q + 6'd1) begin
            state_d = StDone;
          end else begin
            sym_cnt_d = sym_cnt_q + 6'd1;
            start     = 1'b1;
            sym       = sym_for(sym_cnt_q + 6'd1, data_q, par_q, bq_q);
            state_d   = StLow;
          end
        end
      end
      StDone: begin
        bsy_d   = 1'b0;
        txd_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cfg_q     <= CFG_RESET;
      data_q    <= '0;
      bq_q      <= '0;
      sym_cnt_q <= '0;
      par_q     <= 1'b0;
      bsy_q     <= 1'b0;
      txd_q     <= 1'b0;
      crj_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      data_q    <= data_d;
      bq_q      <= bq_d;
      sym_cnt_q <= sym_cnt_d;
      par_q     <= par_d;
      bsy_q     <= bsy_d;
      txd_q     <= txd_d;
      crj_q     <= crj_d;
    end
  end

  sl_symbol_driver #(
    .BitLowCycles(BIT_LOW_CYCLES),
    .GapCycles   (GAP_CYCLES)
  ) u_driver (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .sym_i     (sym),
    .zeroes_o  (serial_line_zeroes),
    .ones_o    (serial_line_ones),
    .low_last_o(low_last),
    .sym_done_o(sym_done)
  );

endmodule

// File: tb/tb_sl_transmitter.sv
module tb_sl_transmitter;

  localparam int LowLen = 16;
  localparam int GapLen = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wr_config_w;
  logic        wr_enable;
  logic [31:0] tx_data_w;
  logic        tx_valid;
  logic        tx_ready;
  logic        zl;
  logic        ol;
  logic [15:0] status_w;
  logic [15:0] r_config_w;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #31 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sl_transmitter dut (
    .clk               (clk),
    .rst               (rst),
    .wr_config_w       (wr_config_w),
    .wr_enable         (wr_enable),
    .tx_data_w         (tx_data_w),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .serial_line_zeroes(zl),
    .serial_line_ones  (ol),
    .status_w          (status_w),
    .r_config_w        (r_config_w)
  );

  typedef struct {
    bit          do_cfg;
    logic [15:0] cfg;
    logic [31:0] data;
    logic [31:0] exp_word;
    logic        exp_par;
    int          nsym;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [15:0] v);
    wr_config_w = v;
    wr_enable   = 1'b1;
    @(negedge clk);
    wr_enable   = 1'b0;
  endtask

  // Called at a negedge while idle; returns the cycle stamp of the first
  // cycle after the accepting edge.
  task automatic send_word(input logic [31:0] d, output int acc);
    tx_data_w = d;
    tx_valid  = 1'b1;
    @(negedge clk);
    acc      = cyc;
    tx_valid = 1'b0;
  endtask

  // Decodes one frame off the lines and checks symbol/gap lengths.
  task automatic capture_frame(input int nsym, output logic [31:0] word, output logic par,
                               output logic stop_ok, output int terr, output int hserr);
    int t;
    int len;
    logic z;
    logic o;
    word = '0; par = 1'b0; stop_ok = 1'b0; terr = 0; hserr = 0;
    for (int s = 0; s < nsym; s++) begin
      t = 0;
      while (zl && ol && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        terr++;
        return;
      end
      if (s > 0 && t != GapLen) terr++;
      z = zl; o = ol; len = 0;
      while (!(zl && ol) && len < 200) begin
        if (zl != z || ol != o) terr++;
        if (tx_ready || !status_w[0]) hserr++;
        len++;
        @(negedge clk);
      end
      if (len != LowLen) terr++;
      if (s < nsym - 2) begin
        if (z == o) terr++;
        word[s] = z & ~o;
      end else if (s == nsym - 2) begin
        par = z & ~o;
      end else begin
        stop_ok = !z && !o;
      end
    end
  endtask

  task automatic wait_txd(output int seen);
    int k = 0;
    while (!status_w[1] && k < 3000) begin
      @(negedge clk);
      k++;
    end
    seen = cyc;
  endtask

  logic [31:0] w, w2;
  logic        p, p2, st, st2;
  int          terr, terr2, hserr, hserr2, acc, seen;
  int          acc_c[2];
  int          n_acc, hs_bad;

  initial begin
    vecs[0] = '{1'b0, 16'h0000, 32'hFFFF_FFA5, 32'h0000_00A5, 1'b1, 10, 321};
    vecs[1] = '{1'b1, 16'h0040, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 34, 1089};
    vecs[2] = '{1'b1, 16'h0011, 32'h0000_0001, 32'h0000_0001, 1'b1, 10, 321};
    vecs[3] = '{1'b1, 16'h0010, 32'h0000_003C, 32'h0000_003C, 1'b1, 10, 321};
    vecs[4] = '{1'b1, 16'h0018, 32'h1234_5ABC, 32'h0000_0ABC, 1'b0, 14, 449};

    rst = 1'b1; wr_config_w = '0; wr_enable = 1'b0; tx_data_w = '0; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset zeroes", zl, 1);
    check("reset ones", ol, 1);
    check("reset tx_ready", tx_ready, 1);
    check("reset status", status_w, 16'h0000);
    check("reset config", r_config_w, 16'h0010);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].do_cfg) begin
        cfg_write(vecs[i].cfg);
        check($sformatf("v%0d config", i), r_config_w, vecs[i].cfg);
        check($sformatf("v%0d crj", i), status_w[2], 0);
      end
      send_word(vecs[i].data, acc);
      check($sformatf("v%0d busy", i), status_w[1:0], 2'b01);
      capture_frame(vecs[i].nsym, w, p, st, terr, hserr);
      check($sformatf("v%0d word", i), w, vecs[i].exp_word);
      check($sformatf("v%0d parity", i), p, vecs[i].exp_par);
      check($sformatf("v%0d stop", i), st, 1);
      check($sformatf("v%0d timing errs", i), terr, 0);
      check($sformatf("v%0d handshake errs", i), hserr, 0);
      wait_txd(seen);
      check($sformatf("v%0d txd latency", i), seen - acc, vecs[i].exp_lat);
      check($sformatf("v%0d status end", i), status_w, 16'h0002);
      check($sformatf("v%0d tx_ready end", i), tx_ready, 1);
    end

    // Out-of-range BQ writes while idle
    cfg_write(16'h000A);
    check("bq5 config kept", r_config_w, 16'h0018);
    check("bq5 crj", status_w[2], 1);
    cfg_write(16'h0042);
    check("bq33 config kept", r_config_w, 16'h0018);
    cfg_write(16'h0010);
    check("valid write config", r_config_w, 16'h0010);
    check("valid write crj clear", status_w[2], 0);

    // Config write during a frame
    send_word(32'h0000_00C3, acc);
    repeat (40) @(negedge clk);
    cfg_write(16'h0018);
    check("busy write config kept", r_config_w, 16'h0010);
    check("busy write crj", status_w[2], 1);
    wait_txd(seen);
    check("busy frame txd", status_w[1], 1);
    cfg_write(16'h0010);
    check("crj cleared again", status_w[2], 0);

    // Word and config write in the same idle cycle
    tx_data_w = 32'h0000_0055; tx_valid = 1'b1;
    wr_config_w = 16'h0018; wr_enable = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0; wr_enable = 1'b0;
    check("simul accepted", tx_ready, 0);
    check("simul status", status_w, 16'h0005);
    check("simul config kept", r_config_w, 16'h0010);
    wait_txd(seen);
    check("simul txd", status_w[1:0], 2'b10);

    // Two words with tx_valid held high
    @(negedge clk);
    n_acc = 0; hs_bad = 0;
    tx_data_w = 32'h0000_003C; tx_valid = 1'b1;
    fork
      begin
        for (int c = 0; c < 1200 && n_acc < 2; c++) begin
          if (tx_ready && status_w[0]) hs_bad++;
          if (tx_ready) begin
            acc_c[n_acc] = cyc;
            n_acc++;
            @(negedge clk);
            if (n_acc == 1) tx_data_w = 32'h0000_00C3;
            else tx_valid = 1'b0;
          end else begin
            @(negedge clk);
          end
        end
        tx_valid = 1'b0;
      end
      begin
        capture_frame(10, w, p, st, terr, hserr);
        capture_frame(10, w2, p2, st2, terr2, hserr2);
      end
    join
    check("b2b accepts", n_acc, 2);
    check("b2b accept spacing", acc_c[1] - acc_c[0], 322);
    check("b2b ready while busy", hs_bad, 0);
    check("b2b word1", w, 32'h3C);
    check("b2b par1", {p, st}, 2'b11);
    check("b2b word2", w2, 32'hC3);
    check("b2b par2", {p2, st2}, 2'b11);
    check("b2b timing", terr + terr2 + hserr + hserr2, 0);
    wait_txd(seen);

    // Reset during the 4th data symbol
    cfg_write(16'h0018);
    @(negedge clk);
    send_word(32'h0000_00A5, acc);
    repeat (100) @(negedge clk);
    check("pre-reset lines low", zl & ol, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid reset lines", {zl, ol}, 2'b11);
    check("mid reset tx_ready", tx_ready, 1);
    check("mid reset status", status_w, 16'h0000);
    check("mid reset config", r_config_w, 16'h0010);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post reset idle lines", {zl, ol}, 2'b11);
    send_word(32'h0000_005A, acc);
    capture_frame(10, w, p, st, terr, hserr);
    check("recover word", w, 32'h5A);
    check("recover par/stop", {p, st}, 2'b11);
    check("recover timing", terr + hserr, 0);
    wait_txd(seen);
    check("recover txd latency", seen - acc, 321);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
